bram_sdp_masked: RTL and testbench

// - Simple-dual-port block RAM with a parametrised read pipeline, per-lane write mask, read-valid tracking and a

---
 rtl/bram_sdp_masked.sv | 111 +++++++++++
 tb/tb_bram_sdp_masked.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_masked.sv
// Simple-dual-port block RAM with per-lane write mask, parametrised read pipeline and a zeroing clear engine.
// Define BRAM_SDP_WRITE_FORWARD_EN for write-first collisions; the default is read-first.
module bram_sdp_masked #(
    parameter int DATA_WIDTH    = 16,
    parameter int LANE_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 11,
    parameter int READ_LATENCY  = 1
) (
    input  logic                               i_clock,
    input  logic                               i_reset_n,
    input  logic                               i_clear,
    output logic                               o_busy,
    input  logic                               i_ren,
    input  logic [ADDRESS_WIDTH-1:0]           i_raddr,
    output logic [DATA_WIDTH-1:0]              o_dout,
    output logic                               o_dvalid,
    input  logic                               i_wen,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   i_wmask,
    input  logic [ADDRESS_WIDTH-1:0]           i_waddr,
    input  logic [DATA_WIDTH-1:0]              i_din
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    // state    | meaning
    // ST_RESET | reset held, ports ignored
    // ST_CLEAR | zeroing mem[r_clr_cnt], one word per cycle
    // ST_READY | normal read/write service
    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDRESS_WIDTH-1:0]   r_clr_cnt;
    logic [DATA_WIDTH-1:0]      r_mem [DEPTH];
    logic [READ_LATENCY-1:0]    r_vld;
    logic [DATA_WIDTH-1:0]      r_data [READ_LATENCY];
    logic [DATA_WIDTH-1:0]      w_rd_word;
    logic                       w_busy;
    logic                       w_rd_acc;
    logic                       w_wr_acc;
    logic                       w_clr_last;

    assign w_busy     = (r_state != ST_READY);
    assign w_rd_acc   = i_ren & ~w_busy;
    assign w_wr_acc   = i_wen & ~w_busy & i_reset_n;
    assign w_clr_last = (r_clr_cnt == {ADDRESS_WIDTH{1'b1}});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET: w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_clr_last) w_state_nxt = ST_READY;
            ST_READY: if (i_clear) w_state_nxt = ST_CLEAR;
            default:  w_state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state   <= ST_RESET;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= (r_state == ST_CLEAR) ? r_clr_cnt + 1'b1 : '0;
        end
    end

    // Clear writes and user writes are mutually exclusive because busy gates the user port.
    always_ff @(posedge i_clock) begin
        if (i_reset_n && r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc) begin
            for (int l = 0; l < LANES; l++) begin
                if (i_wmask[l]) r_mem[i_waddr][l*LANE_WIDTH +: LANE_WIDTH] <= i_din[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

`ifdef BRAM_SDP_WRITE_FORWARD_EN
    always_comb begin
        w_rd_word = r_mem[i_raddr];
        if (w_wr_acc && i_waddr == i_raddr) begin
            for (int l = 0; l < LANES; l++) begin
                if (i_wmask[l]) w_rd_word[l*LANE_WIDTH +: LANE_WIDTH] = i_din[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end
`else
    assign w_rd_word = r_mem[i_raddr];
`endif

    // Data only advances behind a valid so the last stage holds its final valid word.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) r_data[k] <= '0;
        end else begin
            r_vld[0] <= w_rd_acc;
            if (w_rd_acc) r_data[0] <= w_rd_word;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) r_data[k] <= r_data[k-1];
            end
        end
    end

    assign o_busy   = w_busy;
    assign o_dvalid = r_vld[READ_LATENCY-1];
    assign o_dout   = r_data[READ_LATENCY-1];

endmodule

// File: tb/tb_bram_sdp_masked.sv
// Scoreboard bench for bram_sdp_masked at READ_LATENCY=3; collision expectation follows BRAM_SDP_WRITE_FORWARD_EN.
module tb_bram_sdp_masked;
    localparam int DW    = 16;
    localparam int AW    = 11;
    localparam int RL    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n, clr, busy, ren, dvalid, wen;
    logic [AW-1:0] raddr, waddr;
    logic [DW-1:0] dout, din;
    logic [1:0]    wmask;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    bram_sdp_masked #(
        .DATA_WIDTH(DW), .LANE_WIDTH(8), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_clear(clr), .o_busy(busy),
        .i_ren(ren), .i_raddr(raddr), .o_dout(dout), .o_dvalid(dvalid),
        .i_wen(wen), .i_wmask(wmask), .i_waddr(waddr), .i_din(din)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every dvalid must match the oldest outstanding read in data and arrival cycle.
    always @(negedge clk) begin
        if (dvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_dvalid", 32'(dvalid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_data", 32'(dout), 32'(e.d));
                chk("rd_latency", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
        wen = 1'b1; waddr = a; din = d; wmask = m;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    task automatic issue_rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        ren = 1'b1; raddr = a;
        e.d = d; e.c = cyc + RL;
        exp_q.push_back(e);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        issue_rd(a, d);
        @(posedge clk); #1;
        ren = 1'b0;
    endtask

    task automatic drain();
        repeat (RL + 2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 3 * DEPTH) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic [DW-1:0] coll_exp;
        rst_n = 1'b0; clr = 1'b0; ren = 1'b0; wen = 1'b0;
        raddr = '0; waddr = '0; din = '0; wmask = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        busy_len(n);
        chk("init_clear_len", 32'(n), 32'(DEPTH));
        @(posedge clk); #1;

        for (int a = 0; a < DEPTH; a++) begin
            issue_rd(AW'(a), 16'h0000);
            @(posedge clk); #1;
        end
        ren = 1'b0;
        drain();

        wr(11'd5, 16'hBEEF, 2'b11);
        wr(11'd5, 16'h0012, 2'b01);
        rd(11'd5, 16'hBE12);
        wr(11'd5, 16'hFFFF, 2'b00);
        rd(11'd5, 16'hBE12);
        wr(11'(DEPTH - 1), 16'hA5A5, 2'b11);
        wr(11'd0, 16'h5A5A, 2'b10);
        rd(11'(DEPTH - 1), 16'hA5A5);
        rd(11'd0, 16'h5A00);
        drain();

        wr(11'd9, 16'h00AA, 2'b11);
`ifdef BRAM_SDP_WRITE_FORWARD_EN
        coll_exp = 16'h1234;
`else
        coll_exp = 16'h00AA;
`endif
        wen = 1'b1; waddr = 11'd9; din = 16'h1234; wmask = 2'b11;
        rd(11'd9, coll_exp);
        wen = 1'b0;
        rd(11'd9, 16'h1234);
        drain();

        for (int i = 0; i < 4; i++) wr(11'(20 + i), 16'hA020 + 16'(i), 2'b11);
        for (int i = 0; i < 4; i++) begin
            issue_rd(11'(20 + i), 16'hA020 + 16'(i));
            @(posedge clk); #1;
        end
        ren = 1'b0;
        drain();

        wr(11'd7, 16'h5555, 2'b11);
        rd(11'd7, 16'h5555);
        clr = 1'b1;
        issue_rd(11'd5, 16'hBE12);
        @(posedge clk); #1;
        clr = 1'b0; ren = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy && n < 3 * DEPTH) begin
            n++;
            if (n == 100) begin
                wen = 1'b1; waddr = 11'd3; din = 16'hFFFF; wmask = 2'b11;
                ren = 1'b1; raddr = 11'd3;
            end else begin
                wen = 1'b0; ren = 1'b0;
            end
            @(negedge clk);
        end
        wen = 1'b0; ren = 1'b0;
        chk("clear_len", 32'(n), 32'(DEPTH));
        @(posedge clk); #1;
        rd(11'd7, 16'h0000);
        rd(11'd3, 16'h0000);
        rd(11'd5, 16'h0000);
        drain();

        wr(11'd5, 16'h1111, 2'b11);
        rd(11'd5, 16'h1111);
        drain();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midclr_rst_busy", 32'(busy), 32'd1);
        chk("midclr_rst_dvalid", 32'(dvalid), 32'd0);
        chk("midclr_rst_dout", 32'(dout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        busy_len(n);
        chk("restart_clear_len", 32'(n), 32'(DEPTH));
        @(posedge clk); #1;
        rd(11'd5, 16'h0000);
        rd(11'(DEPTH - 1), 16'h0000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
